// File: rtl/debug_program_loader_if.sv
// ---------------------------------------------------------------------------
// debug_program_loader_if
// Bundle of the loader's control inputs and memory debug-port outputs.
//   i_start       : 1-cycle strobe that begins a load
//   i_rx_data     : received byte, valid while i_rx_done is high
//   i_rx_done     : 1-cycle strobe from the UART receiver
//   o_DirecDebug  : instruction-memory write address (byte address, step 4)
//   o_DatoDebug   : instruction-memory write data
//   o_WriteDebug  : write strobe, memory samples on its rising edge
//   o_busy        : load in progress
//   o_done        : load finished
//   o_overrun     : sticky, a byte arrived while not receiving
//   o_overflow    : sticky, memory filled before the halt word
//   o_word_count  : words written in the current load
// Modports: master = the loader, slave = the debug unit / memory side.
// ---------------------------------------------------------------------------
interface debug_program_loader_if #(
   parameter int NBITS = 32,
   parameter int NBYTE = 8
);
   logic             i_start;
   logic [NBYTE-1:0] i_rx_data;
   logic             i_rx_done;
   logic [NBITS-1:0] o_DirecDebug;
   logic [NBITS-1:0] o_DatoDebug;
   logic             o_WriteDebug;
   logic             o_busy;
   logic             o_done;
   logic             o_overrun;
   logic             o_overflow;
   logic [NBITS-1:0] o_word_count;

   modport master (
      input  i_start, i_rx_data, i_rx_done,
      output o_DirecDebug, o_DatoDebug, o_WriteDebug, o_busy, o_done,
             o_overrun, o_overflow, o_word_count
   );

   modport slave (
      output i_start, i_rx_data, i_rx_done,
      input  o_DirecDebug, o_DatoDebug, o_WriteDebug, o_busy, o_done,
             o_overrun, o_overflow, o_word_count
   );
endinterface

// File: rtl/debug_program_loader.sv
// ---------------------------------------------------------------------------
// debug_program_loader
// Assembles big-endian words from a UART byte stream and writes them into
// instruction memory at consecutive word addresses, stopping after the halt
// word or when the last memory cell has been written.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   bus     : debug_program_loader_if.master (start/byte inputs, memory
//             write port and status outputs)
// Every output is a flop; nothing from the inputs reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module debug_program_loader #(
   parameter int                NBITS      = 32,
   parameter int                NBYTE      = 8,
   parameter int                CELDAS     = 256,
   parameter int unsigned       START_ADDR = 0,
   parameter logic [NBITS-1:0]  HALT_WORD  = {NBITS{1'b1}}
) (
   input logic                    i_clk,
   input logic                    i_reset,
   debug_program_loader_if.master bus
);

   localparam int               BYTES     = NBITS / NBYTE;
   localparam int               CW        = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0]    LAST_CNT  = CW'(BYTES - 1);
   localparam logic [NBITS-1:0] FIRST     = NBITS'(START_ADDR);
   localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);
   localparam logic [NBITS-1:0] STEP      = NBITS'(4);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      SETUP = 3'd2,
      WRITE = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t state, state_n;

   // Only the upper NBITS-NBYTE bits are kept; the final byte is appended
   // directly when the word is transferred to the data register.
   logic [NBITS-NBYTE-1:0] shift, shift_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [NBITS-1:0]       addr, addr_n;
   logic [NBITS-1:0]       data, data_n;
   logic [NBITS-1:0]       wcount, wcount_n;
   logic                   overrun, overrun_n;
   logic                   overflow, overflow_n;
   logic                   write, write_n;
   logic                   busy, busy_n;
   logic                   done, done_n;

   logic is_halt;
   logic is_last;

   assign is_halt = (data == HALT_WORD);
   assign is_last = (addr == LAST_ADDR);

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.i_start) state_n = RECV;
         RECV:    if (bus.i_rx_done && cnt == LAST_CNT) state_n = SETUP;
         SETUP:   state_n = WRITE;
         WRITE:   state_n = HOLD;
         HOLD:    state_n = (is_halt || is_last) ? DONE : RECV;
         DONE:    if (bus.i_start) state_n = RECV;
         default: state_n = IDLE;
      endcase
   end

   // Output / datapath next values. Status flags are derived from the next
   // state so that they line up with the state they describe.
   always_comb begin
      shift_n    = shift;
      cnt_n      = cnt;
      addr_n     = addr;
      data_n     = data;
      wcount_n   = wcount;
      overrun_n  = overrun;
      overflow_n = overflow;
      case (state)
         IDLE, DONE: begin
            if (bus.i_start) begin
               addr_n     = FIRST;
               cnt_n      = '0;
               wcount_n   = '0;
               overrun_n  = 1'b0;
               overflow_n = 1'b0;
            end else if (state == DONE && bus.i_rx_done) begin
               overrun_n = 1'b1;
            end
         end
         RECV: begin
            if (bus.i_rx_done) begin
               if (NBITS - NBYTE > NBYTE)
                  shift_n = {shift[NBITS-2*NBYTE-1:0], bus.i_rx_data};
               else
                  shift_n = bus.i_rx_data[NBITS-NBYTE-1:0];
               if (cnt == LAST_CNT) begin
                  data_n = {shift, bus.i_rx_data};
                  cnt_n  = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         SETUP, WRITE: begin
            if (bus.i_rx_done) overrun_n = 1'b1;
         end
         HOLD: begin
            if (bus.i_rx_done) overrun_n = 1'b1;
            wcount_n = wcount + NBITS'(1);
            // Fullness is tested before the increment, so the address never wraps.
            if (!is_halt) begin
               if (is_last) overflow_n = 1'b1;
               else         addr_n     = addr + STEP;
            end
         end
         default: ;
      endcase
      write_n = (state_n == WRITE);
      busy_n  = (state_n == RECV) || (state_n == SETUP) ||
                (state_n == WRITE) || (state_n == HOLD);
      done_n  = (state_n == DONE);
   end

   // Output and datapath registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         shift    <= '0;
         cnt      <= '0;
         addr     <= FIRST;
         data     <= '0;
         wcount   <= '0;
         overrun  <= 1'b0;
         overflow <= 1'b0;
         write    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         shift    <= shift_n;
         cnt      <= cnt_n;
         addr     <= addr_n;
         data     <= data_n;
         wcount   <= wcount_n;
         overrun  <= overrun_n;
         overflow <= overflow_n;
         write    <= write_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   assign bus.o_DirecDebug = addr;
   assign bus.o_DatoDebug  = data;
   assign bus.o_WriteDebug = write;
   assign bus.o_busy       = busy;
   assign bus.o_done       = done;
   assign bus.o_overrun    = overrun;
   assign bus.o_overflow   = overflow;
   assign bus.o_word_count = wcount;

endmodule

// File: tb/tb_debug_program_loader.sv
// ---------------------------------------------------------------------------
// tb_debug_program_loader
// Drives two loaders (default memory size and a 16-cell memory) from shared
// stimulus selected by 'sel'. Expected memory writes are queued as words are
// sent and popped by a memory model on each rising write strobe.
// ---------------------------------------------------------------------------
module tb_debug_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rx_done = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] rx_data = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   debug_program_loader_if #(.NBITS(32), .NBYTE(8)) bif_a ();
   debug_program_loader_if #(.NBITS(32), .NBYTE(8)) bif_b ();

   assign bif_a.i_start   = start & ~sel;
   assign bif_a.i_rx_done = rx_done & ~sel;
   assign bif_a.i_rx_data = rx_data;
   assign bif_b.i_start   = start & sel;
   assign bif_b.i_rx_done = rx_done & sel;
   assign bif_b.i_rx_data = rx_data;

   debug_program_loader #(.CELDAS(256)) dut_a (.i_clk(clk), .i_reset(rst), .bus(bif_a));
   debug_program_loader #(.CELDAS(16))  dut_b (.i_clk(clk), .i_reset(rst), .bus(bif_b));

   // Scoreboard entries are {address, data}
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];
   logic [63:0] exp_a, exp_b;
   logic [31:0] mem_a[64];
   logic [31:0] mem_b[4];
   logic        prev_a = 1'b0;
   logic        prev_b = 1'b0;

   always @(negedge clk) begin
      if (bif_a.o_WriteDebug && !prev_a) begin
         n_checks++;
         if (q_a.size() == 0) begin
            n_fail++;
            $display("FAIL write_a_unexpected: addr=%h data=%h, required no write",
                     bif_a.o_DirecDebug, bif_a.o_DatoDebug);
         end else begin
            exp_a = q_a.pop_front();
            if ({bif_a.o_DirecDebug, bif_a.o_DatoDebug} !== exp_a) begin
               n_fail++;
               $display("FAIL write_a: addr=%h data=%h, required addr=%h data=%h",
                        bif_a.o_DirecDebug, bif_a.o_DatoDebug, exp_a[63:32], exp_a[31:0]);
            end
         end
         mem_a[bif_a.o_DirecDebug[7:2]] <= bif_a.o_DatoDebug;
      end
      prev_a <= bif_a.o_WriteDebug;
   end

   always @(negedge clk) begin
      if (bif_b.o_WriteDebug && !prev_b) begin
         n_checks++;
         if (q_b.size() == 0) begin
            n_fail++;
            $display("FAIL write_b_unexpected: addr=%h data=%h, required no write",
                     bif_b.o_DirecDebug, bif_b.o_DatoDebug);
         end else begin
            exp_b = q_b.pop_front();
            if ({bif_b.o_DirecDebug, bif_b.o_DatoDebug} !== exp_b) begin
               n_fail++;
               $display("FAIL write_b: addr=%h data=%h, required addr=%h data=%h",
                        bif_b.o_DirecDebug, bif_b.o_DatoDebug, exp_b[63:32], exp_b[31:0]);
            end
         end
         mem_b[bif_b.o_DirecDebug[3:2]] <= bif_b.o_DatoDebug;
      end
      prev_b <= bif_b.o_WriteDebug;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   // Sends a word MSB first and waits until the loader is back in RECV/DONE.
   task automatic send_word(input logic [31:0] w, input logic [31:0] a);
      if (sel) q_b.push_back({a, w});
      else     q_a.push_back({a, w});
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
      repeat (3) tick();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      n_checks++;
      if ({bif_a.o_DirecDebug, bif_a.o_DatoDebug, bif_a.o_word_count} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_regs: addr=%h data=%h count=%0d, required all 0",
                  bif_a.o_DirecDebug, bif_a.o_DatoDebug, bif_a.o_word_count);
      end
      n_checks++;
      if ({bif_a.o_WriteDebug, bif_a.o_busy, bif_a.o_done, bif_a.o_overrun, bif_a.o_overflow} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: wr/busy/done/ovr/ovf=%b, required 00000",
                  {bif_a.o_WriteDebug, bif_a.o_busy, bif_a.o_done, bif_a.o_overrun, bif_a.o_overflow});
      end
      tick();
      rst = 1'b0;
      tick();
      // A byte in IDLE is ignored without overrun
      send_byte(8'h55);
      @(negedge clk);
      n_checks++;
      if ({bif_a.o_overrun, bif_a.o_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_byte: overrun=%b busy=%b, required 0 0", bif_a.o_overrun, bif_a.o_busy);
      end
      tick();
   endtask

   task automatic test_basic();
      pulse_start();
      @(negedge clk);
      n_checks++;
      if (bif_a.o_busy !== 1'b1 || bif_a.o_DirecDebug !== 32'h0) begin
         n_fail++;
         $display("FAIL start_busy: busy=%b addr=%h, required 1 00000000", bif_a.o_busy, bif_a.o_DirecDebug);
      end
      tick();
      send_word(32'h00220820, 32'h0);
      send_word(32'h00010822, 32'h4);
      @(negedge clk);
      n_checks++;
      if (bif_a.o_word_count !== 32'd2 || bif_a.o_busy !== 1'b1 || bif_a.o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_status: count=%0d busy=%b done=%b, required 2 1 0",
                  bif_a.o_word_count, bif_a.o_busy, bif_a.o_done);
      end
      n_checks++;
      if (mem_a[0] !== 32'h00220820 || mem_a[1] !== 32'h00010822) begin
         n_fail++;
         $display("FAIL basic_mem: mem0=%h mem1=%h, required 00220820 00010822", mem_a[0], mem_a[1]);
      end
      tick();
   endtask

   task automatic test_halt();
      apply_reset();
      pulse_start();
      send_word(32'h12345678, 32'h0);
      send_word(32'hFFFFFFFF, 32'h4);
      @(negedge clk);
      n_checks++;
      if (bif_a.o_done !== 1'b1 || bif_a.o_busy !== 1'b0 || bif_a.o_word_count !== 32'd2 ||
          bif_a.o_DirecDebug !== 32'h4 || bif_a.o_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_status: done=%b busy=%b count=%0d addr=%h ovf=%b, required 1 0 2 00000004 0",
                  bif_a.o_done, bif_a.o_busy, bif_a.o_word_count, bif_a.o_DirecDebug, bif_a.o_overflow);
      end
      n_checks++;
      if (mem_a[1] !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL halt_mem: mem1=%h, required ffffffff", mem_a[1]);
      end
      tick();
      send_byte(8'h77);
      @(negedge clk);
      n_checks++;
      if (bif_a.o_overrun !== 1'b1 || bif_a.o_done !== 1'b1 || bif_a.o_word_count !== 32'd2) begin
         n_fail++;
         $display("FAIL done_overrun: overrun=%b done=%b count=%0d, required 1 1 2",
                  bif_a.o_overrun, bif_a.o_done, bif_a.o_word_count);
      end
      tick();
      // Start and byte together in DONE: start wins, no overrun
      start   = 1'b1;
      rx_data = 8'h99;
      rx_done = 1'b1;
      tick();
      start   = 1'b0;
      rx_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bif_a.o_overrun !== 1'b0 || bif_a.o_busy !== 1'b1 || bif_a.o_done !== 1'b0 ||
          bif_a.o_word_count !== 32'd0 || bif_a.o_DirecDebug !== 32'h0) begin
         n_fail++;
         $display("FAIL restart: overrun=%b busy=%b done=%b count=%0d addr=%h, required 0 1 0 0 00000000",
                  bif_a.o_overrun, bif_a.o_busy, bif_a.o_done, bif_a.o_word_count, bif_a.o_DirecDebug);
      end
      tick();
   endtask

   task automatic test_timing();
      logic [31:0] w;
      int          strobes;
      w       = 32'hA5C30F96;
      strobes = 0;
      q_a.push_back({32'h0, w});
      for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8]);
      send_byte(w[7:0]);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (bif_a.o_WriteDebug) strobes++;
         n_checks++;
         if (bif_a.o_WriteDebug !== (c == 2)) begin
            n_fail++;
            $display("FAIL strobe_n%0d: write=%b, required %b", c + 1, bif_a.o_WriteDebug, (c == 2));
         end
         if (c <= 3) begin
            n_checks++;
            if (bif_a.o_DirecDebug !== 32'h0 || bif_a.o_DatoDebug !== w) begin
               n_fail++;
               $display("FAIL stable_n%0d: addr=%h data=%h, required 00000000 %h",
                        c + 1, bif_a.o_DirecDebug, bif_a.o_DatoDebug, w);
            end
         end else begin
            n_checks++;
            if (bif_a.o_DirecDebug !== 32'h4) begin
               n_fail++;
               $display("FAIL addr_step: addr=%h, required 00000004", bif_a.o_DirecDebug);
            end
         end
      end
      n_checks++;
      if (strobes !== 1) begin
         n_fail++;
         $display("FAIL strobe_width: cycles=%0d, required 1", strobes);
      end
      tick();
   endtask

   task automatic test_overrun_write();
      logic [31:0] w;
      w = 32'h0BADF00D;
      q_a.push_back({32'h4, w});
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
      tick();                      // now in WRITE
      rx_data = 8'hEE;
      rx_done = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bif_a.o_WriteDebug !== 1'b1) begin
         n_fail++;
         $display("FAIL inject_phase: write=%b, required 1", bif_a.o_WriteDebug);
      end
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bif_a.o_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL write_overrun: overrun=%b, required 1", bif_a.o_overrun);
      end
      tick();
      tick();
      send_word(32'hCAFE1234, 32'h8);
      @(negedge clk);
      n_checks++;
      if (bif_a.o_overrun !== 1'b1 || bif_a.o_word_count !== 32'd3 || mem_a[2] !== 32'hCAFE1234) begin
         n_fail++;
         $display("FAIL after_overrun: overrun=%b count=%0d mem2=%h, required 1 3 cafe1234",
                  bif_a.o_overrun, bif_a.o_word_count, mem_a[2]);
      end
      tick();
   endtask

   task automatic test_reset_midword();
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      #2;
      n_checks++;
      if ({bif_a.o_DirecDebug, bif_a.o_DatoDebug, bif_a.o_word_count} !== 96'h0 ||
          {bif_a.o_WriteDebug, bif_a.o_busy, bif_a.o_done, bif_a.o_overrun, bif_a.o_overflow} !== 5'b0) begin
         n_fail++;
         $display("FAIL async_reset: addr=%h data=%h count=%0d flags=%b, required all 0",
                  bif_a.o_DirecDebug, bif_a.o_DatoDebug, bif_a.o_word_count,
                  {bif_a.o_WriteDebug, bif_a.o_busy, bif_a.o_done, bif_a.o_overrun, bif_a.o_overflow});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      pulse_start();
      send_word(32'h13572468, 32'h0);
      @(negedge clk);
      n_checks++;
      if (bif_a.o_word_count !== 32'd1 || bif_a.o_DirecDebug !== 32'h4 || mem_a[0] !== 32'h13572468) begin
         n_fail++;
         $display("FAIL reload: count=%0d addr=%h mem0=%h, required 1 00000004 13572468",
                  bif_a.o_word_count, bif_a.o_DirecDebug, mem_a[0]);
      end
      tick();
   endtask

   task automatic test_overflow();
      sel = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++)
         send_word(32'h01010101 * (k + 1), 32'(4 * k));
      @(negedge clk);
      n_checks++;
      if (bif_b.o_done !== 1'b1 || bif_b.o_overflow !== 1'b1 || bif_b.o_DirecDebug !== 32'd12 ||
          bif_b.o_word_count !== 32'd4 || bif_b.o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow: done=%b ovf=%b addr=%h count=%0d busy=%b, required 1 1 0000000c 4 0",
                  bif_b.o_done, bif_b.o_overflow, bif_b.o_DirecDebug, bif_b.o_word_count, bif_b.o_busy);
      end
      n_checks++;
      if (mem_b[0] !== 32'h01010101 || mem_b[3] !== 32'h04040404) begin
         n_fail++;
         $display("FAIL overflow_mem: mem0=%h mem3=%h, required 01010101 04040404", mem_b[0], mem_b[3]);
      end
      tick();
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_halt();
      test_timing();
      test_overrun_write();
      test_reset_midword();
      test_overflow();
      repeat (2) tick();
      n_checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_fail++;
         $display("FAIL pending_writes: a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/debug_program_loader.md
Name: debug_program_loader

Overview:
Loader side of the instruction-memory debug write port. Receives a byte stream from the debug UART receiver and assembles big-endian 32-bit words. Writes each word into instruction memory through the address/data/write-strobe interface at consecutive word addresses (step 4, matching the PC byte addressing). Stops after writing the halt word or when memory is full, then reports completion to the debug unit.

Parameters:
NBITS, 32, instruction word and debug address width
NBYTE, 8, width of the received byte
CELDAS, 256, instruction memory cells; the highest writable address is CELDAS-4
START_ADDR, 0, address of the first loaded word
HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to memory before stopping

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  1-cycle strobe; begins a load
i_rx_data  input  NBYTE  received byte; valid when i_rx_done=1
i_rx_done  input  1  1-cycle strobe from the UART receiver
o_DirecDebug  output  NBITS  memory write address
o_DatoDebug  output  NBITS  memory write data
o_WriteDebug  output  1  write strobe; memory samples on its rising edge
o_busy  output  1  high in RECV/SETUP/WRITE/HOLD
o_done  output  1  high in DONE
o_overrun  output  1  sticky; a byte arrived while not in RECV
o_overflow  output  1  sticky; memory filled before the halt word
o_word_count  output  NBITS  number of words written in the current load

Behaviour:
- Reset (async) values:
  - state=IDLE, byte count=0.
  - o_DirecDebug=START_ADDR, all other outputs 0.
  - A partial word is discarded. Words already written stay in memory.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- IDLE:
  - i_start -> RECV. Address=START_ADDR, byte count=0, o_word_count=0, o_overrun=0, o_overflow=0.
  - i_rx_done is ignored in IDLE and does not set overrun.
- RECV:
  - Each i_rx_done shifts the byte in, MSB first: word = {word[NBITS-NBYTE-1:0], i_rx_data}, count+1.
  - On the 4th byte the assembled word is loaded into o_DatoDebug, count resets to 0, next state SETUP.
  - i_start is ignored.
- Write timing: if the 4th byte strobes in cycle N, then:
  - SETUP (N+1): address and data valid, o_WriteDebug=0.
  - WRITE (N+2): o_WriteDebug=1.
  - HOLD (N+3): o_WriteDebug=0. Address and data are held unchanged from N+1 through N+3.
  - So the strobe is exactly 1 cycle wide, with 1 cycle of setup and 1 cycle of hold.
- Leaving HOLD:
  - o_word_count += 1.
  - If word == HALT_WORD -> DONE, address unchanged.
  - Else if address == CELDAS-4 -> DONE with o_overflow=1.
  - Else address += 4 -> RECV.
- i_rx_done in SETUP, WRITE, HOLD or DONE: the byte is dropped and o_overrun=1 (sticky until the next i_start or reset). The FSM is unaffected.
- DONE:
  - o_done=1, address, data and count held.
  - i_start -> RECV with the same initialisation as from IDLE.
- Address arithmetic is NBITS wide and unsigned. There is no wrap: the full check happens before the increment.
- A simultaneous i_start and i_rx_done in IDLE or DONE: i_start is taken and the byte is ignored without overrun.

Test Plan:
- Reset, i_start, then bytes 00 22 08 20 and 00 01 08 22 -> writes 0x00220820 at addr 0 and 0x00010822 at addr 4. o_word_count=2, o_busy=1, o_done=0.
- Bytes FF FF FF FF after one normal word -> halt word written at addr 4, then o_done=1 and o_word_count=2. A further byte sets o_overrun=1.
- Strobe timing on one word -> o_WriteDebug high exactly 1 cycle, at N+2. Address and data stable from N+1 to N+3. The bench models memory on posedge o_WriteDebug and compares contents.
- CELDAS=16, load 4 non-halt words -> writes at addr 0, 4, 8, 12, then DONE with o_overflow=1 and o_DirecDebug=12.
- A byte injected during WRITE -> o_overrun=1, the byte is not included in the next word, and the next 4 valid bytes form a correct word.
- Assert i_reset after 2 bytes of the 2nd word -> all outputs return to reset values. A new i_start followed by 4 bytes writes at addr 0.
